sync_fifo_fwft: RTL

//  Single-clock first-word-fall-through FIFO controller wrapped around the team's sync_dpram.

---
 rtl/sync_fifo_fwft_pkg.sv | 21 ++
 rtl/sync_dpram.sv | 36 +++
 rtl/sync_fifo_fwft.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared definitions for the sync_fifo_fwft controller: occupancy counter update encoding.
package sync_fifo_fwft_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Simultaneous increment and decrement cancel out.
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
    cnt_op_e op;
    case ({inc, dec})
      2'b10:   op = CNT_INC;
      2'b01:   op = CNT_DEC;
      default: op = CNT_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sync_dpram.sv
// Simple dual-port RAM: synchronous write, registered read address (one-cycle read latency).
// The read-address register only loads on rd_en, so a stalled read keeps its output stable.
module sync_dpram #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 6
) (
  input  logic              wr_clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_clk,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];
  logic [AWIDTH-1:0] rd_addr_q;

  // Write port
  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read address register
  always_ff @(posedge rd_clk) begin
    if (rd_en) begin
      rd_addr_q <= rd_addr;
    end
  end

  assign rd_data = mem_q[rd_addr_q];

endmodule

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO around sync_dpram with a fetch stage plus output register.
// Optional sticky overflow/underflow flags are enabled by defining SYNC_FIFO_ERRFLAG_EN.
module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic              empty,
  output logic [AWIDTH:0]   count
`ifdef SYNC_FIFO_ERRFLAG_EN
  ,
  output logic              ovf,
  output logic              udf,
  input  logic              err_clr
`endif
);

  localparam int CW = AWIDTH + 1;
  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [AWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     mem_cnt_q, mem_cnt_d, count_q, count_d;
  logic              pend_q, pend_d, out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] rd_data_q, rd_data_d, ram_rdata_s;
  logic              full_s, wr_acc_s, pop_s, advance_s, fetch_s;

  assign full_s    = (count_q == CW'(DEPTH));
  assign wr_acc_s  = wr_en && !full_s;
  assign pop_s     = rd_en && out_valid_q;
  assign advance_s = pend_q && (!out_valid_q || pop_s);
  assign fetch_s   = (mem_cnt_q != '0) && (!pend_q || advance_s);

  sync_dpram #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .wr_clk (clk),
    .wr_en  (wr_acc_s),
    .wr_addr(wptr_q),
    .wr_data(wr_data),
    .rd_clk (clk),
    .rd_en  (fetch_s),
    .rd_addr(rptr_q),
    .rd_data(ram_rdata_s)
  );

  // Next-state for pointers, counters and the two prefetch stages
  always_comb begin
    wptr_d      = wr_acc_s ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d      = fetch_s ? (rptr_q + PTR_ONE) : rptr_q;
    rd_data_d   = advance_s ? ram_rdata_s : rd_data_q;
    mem_cnt_d   = mem_cnt_q;
    count_d     = count_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;

    case (cnt_op(wr_acc_s, fetch_s))
      CNT_INC: mem_cnt_d = mem_cnt_q + CNT_ONE;
      CNT_DEC: mem_cnt_d = mem_cnt_q - CNT_ONE;
      default: mem_cnt_d = mem_cnt_q;
    endcase

    case (cnt_op(wr_acc_s, pop_s))
      CNT_INC: count_d = count_q + CNT_ONE;
      CNT_DEC: count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A fetch refills the stage even when it advances in the same cycle.
    if (fetch_s) begin
      pend_d = 1'b1;
    end else if (advance_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (advance_s) begin
      out_valid_d = 1'b1;
    end else if (pop_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      mem_cnt_q   <= '0;
      count_q     <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_cnt_q   <= mem_cnt_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign empty   = !out_valid_q;
  assign full    = full_s;
  assign count   = count_q;

`ifdef SYNC_FIFO_ERRFLAG_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Sticky error flags; a new event wins over err_clr
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (wr_en && full_s) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (rd_en && !out_valid_q) begin
      udf_d = 1'b1;
    end else if (err_clr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Error flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule
